// File: rtl/counter_capture_monitor.sv
// counter_capture_monitor
// Samples the live cluster count into a small first-word-fall-through FIFO
// when capture is high. Snapshots leave the FIFO on a valid/ready interface.
// The block also keeps a saturating count of counter wrap events, where a
// wrap is any decrease of the observed count between two cycles.
module counter_capture_monitor #(
   parameter int WIDTH  = 36,
   parameter int DEPTH  = 4,
   parameter int WRAP_W = 8,
   parameter int LVL_W  = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              capture,
   output logic [WIDTH-1:0]  snap_data,
   output logic              snap_valid,
   input  logic              snap_ready,
   output logic [LVL_W-1:0]  level,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  LVL_ZERO  = {LVL_W{1'b0}};
   localparam logic [LVL_W-1:0]  LVL_ONE   = {{(LVL_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};
   localparam logic [WRAP_W-1:0] WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]  mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic [WIDTH-1:0]  snap_data_r;
   logic [WRAP_W-1:0] wrap_count_r;
   logic              overflow_r;
   logic [WIDTH-1:0]  prev_r;
   logic              prev_ok_r;

   logic              full_s;
   logic              empty_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic              wrap_s;
   logic [PTR_W-1:0]  rd_ptr_nxt_s;
   logic [LVL_W-1:0]  remain_s;
   logic [LVL_W-1:0]  level_nxt_s;
   logic [WIDTH-1:0]  head_nxt_s;

   assign full_s  = (level_r == DEPTH_LVL);
   assign empty_s = (level_r == LVL_ZERO);
   assign pop_s   = !empty_s && snap_ready;
   assign push_s  = capture && (!full_s || pop_s);
   assign drop_s  = capture && full_s && !pop_s;
   assign wrap_s  = prev_ok_r && (count_in < prev_r);

   // Next read pointer, entries left after the pop, and the next level.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      remain_s     = level_r;
      level_nxt_s  = level_r;
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
         remain_s     = level_r - LVL_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
         remain_s     = level_r;
      end
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // The next head comes from storage. If storage will be empty, it is the
   // incoming sample. Otherwise the last value is held.
   always_comb begin
      head_nxt_s = snap_data_r;
      if (remain_s != LVL_ZERO) begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end else if (push_s) begin
         head_nxt_s = count_in;
      end else begin
         head_nxt_s = snap_data_r;
      end
   end

   // FIFO storage, pointers, occupancy and the registered head.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         level_r     <= LVL_ZERO;
         snap_data_r <= {WIDTH{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= count_in;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r    <= rd_ptr_nxt_s;
         level_r     <= level_nxt_s;
         snap_data_r <= head_nxt_s;
      end
   end

   // Sticky flag for a capture lost to a full FIFO. Only reset clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Track the previous count and a saturating count of decreases (wraps).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_r       <= {WIDTH{1'b0}};
         prev_ok_r    <= 1'b0;
         wrap_count_r <= {WRAP_W{1'b0}};
      end else begin
         prev_r    <= count_in;
         prev_ok_r <= 1'b1;
         if (wrap_s && (wrap_count_r != WRAP_MAX)) begin
            wrap_count_r <= wrap_count_r + WRAP_ONE;
         end else begin
            wrap_count_r <= wrap_count_r;
         end
      end
   end

   assign snap_data  = snap_data_r;
   assign snap_valid = !empty_s;
   assign level      = level_r;
   assign wrap_count = wrap_count_r;
   assign overflow   = overflow_r;

endmodule
